mem_stage_wb: RTL and testbench

Memory-access stage of the 5-stage pipeline CPU: consumes the EX/MEM pipeline-register outputs, drives the data-memory request/ready handshake, resolves branches, and registers the results into the MEM/WB pipeline register. It generates `mem_stall` to freeze PC, IF/ID, ID/EX and EX/MEM while a data-memory access waits, and inserts a bubble into MEM/WB during the wait.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/load_align.sv | 36 +++
 rtl/mem_stage_wb.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage_wb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, MemtoReg encodings, MEM-stage FSM states
// and the access-size decode used by the store and load-alignment paths.
package cpu_pkg;

  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU  = 6'h24;
  localparam logic [5:0] OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SB   = 6'h28;
  localparam logic [5:0] OP_SH   = 6'h29;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC  = 2'd2;

  typedef enum logic { ST_IDLE = 1'b0, ST_WAIT = 1'b1 } mem_state_e;

  typedef enum logic [1:0] { SZ_BYTE, SZ_HALF, SZ_WORD } acc_size_e;

  // Unknown opcodes that still carry an access flag fall back to a word access.
  function automatic acc_size_e access_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_signed_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/load_align.sv
// Load-data alignment: selects the addressed byte/half lane of the read word
// and sign- or zero-extends it according to the load opcode.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [5:0]  opcode,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic        sext;

  assign sext = is_signed_load(opcode);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    shifted = rdata;
    data    = rdata;
    case (access_size(opcode))
      SZ_BYTE: begin
        shifted = rdata >> {addr, 3'b000};
        data    = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      // A misaligned half (addr[0]=1) still reads the lane picked by addr[1].
      SZ_HALF: begin
        shifted = rdata >> {addr[1], 4'b0000};
        data    = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_wb.sv
// MEM stage with data-memory handshake, branch resolution and MEM/WB register.
// Optional access timeout and sticky error flag: define MEM_TIMEOUT_EN.
module mem_stage_wb
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] add_result_in,
  input  logic [31:0] result_in,
  input  logic [31:0] Read_2_in,
  input  logic [2:0]  zero_in,
  input  logic [4:0]  RtorRd_in,
  input  logic [5:0]  OpCode_in,
  input  logic        MemWr_in,
  input  logic        MemRead_in,
  input  logic        Branch_in,
  input  logic        RegWr_in,
  input  logic [1:0]  MemtoReg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        pc_src_o,
  output logic [31:0] branch_target_o,
  output logic [31:0] mem_data_o,
  output logic [31:0] result_o,
  output logic [4:0]  RtorRd_o,
  output logic [1:0]  MemtoReg_o,
  output logic        RegWr_o,
  output logic        mem_err_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_stage_wb: TIMEOUT_CYCLES must be in 1..255");
  end

  mem_state_e  state_q, state_d;
  acc_size_e   size;
  logic        access, is_store, is_load, complete, timeout_hit, br_cond;
  logic [31:0] load_data;

  logic [31:0] mem_data_q, mem_data_d, result_q, result_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  mtr_q, mtr_d;
  logic        regwr_q, regwr_d;

  // A store wins when both access flags are set.
  assign access   = MemRead_in | MemWr_in;
  assign is_store = MemWr_in;
  assign is_load  = MemRead_in & ~MemWr_in;
  assign size     = access_size(OpCode_in);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;

  // The Nth WAIT cycle is the one where the counter still reads N-1.
  assign timeout_hit = access & (state_q == ST_WAIT) & ~dmem_ready &
                       (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q + 8'd1;
    mem_err_d = mem_err_q | timeout_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err_o = mem_err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err_o   = 1'b0;
`endif

  assign complete  = access & (dmem_ready | timeout_hit);
  // Request and stall are gated by reset so they fall the moment reset rises.
  assign mem_stall = access & ~complete & ~reset;
  assign dmem_req  = access & ~reset;
  assign dmem_we   = dmem_req & is_store;
  assign dmem_addr = {result_in[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'h0;
    dmem_wdata = Read_2_in;
    case (size)
      SZ_BYTE: begin
        dmem_be    = 4'b0001 << result_in[1:0];
        dmem_wdata = {4{Read_2_in[7:0]}};
      end
      SZ_HALF: begin
        dmem_be    = 4'b0011 << {result_in[1], 1'b0};
        dmem_wdata = {2{Read_2_in[15:0]}};
      end
      default: dmem_be = 4'hF;
    endcase
    if (!access) dmem_be = 4'h0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access && !complete) state_d = ST_WAIT;
      ST_WAIT: if (complete || !access) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .addr   (result_in[1:0]),
    .opcode (OpCode_in),
    .data   (load_data)
  );

  // A stall cycle inserts a bubble: write-enable and MemtoReg clear, the rest hold.
  always_comb begin
    mem_data_d = mem_data_q;
    result_d   = result_q;
    rd_d       = rd_q;
    mtr_d      = mtr_q;
    regwr_d    = 1'b0;
    if (mem_stall) begin
      mtr_d = MTR_ALU;
    end else begin
      mem_data_d = (is_load && !timeout_hit) ? load_data : 32'h0;
      result_d   = result_in;
      rd_d       = RtorRd_in;
      mtr_d      = MemtoReg_in;
      regwr_d    = RegWr_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always_ff blocks execute in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_data_q <= '0;
      result_q   <= '0;
      rd_q       <= '0;
      mtr_q      <= '0;
      regwr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_data_q <= mem_data_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      mtr_q      <= mtr_d;
      regwr_q    <= regwr_d;
    end
  end

  assign mem_data_o = mem_data_q;
  assign result_o   = result_q;
  assign RtorRd_o   = rd_q;
  assign MemtoReg_o = mtr_q;
  assign RegWr_o    = regwr_q;

  always_comb begin
    br_cond = 1'b0;
    case (OpCode_in)
      OP_BEQ:  br_cond = zero_in[0];
      OP_BNE:  br_cond = ~zero_in[0];
      OP_BLEZ: br_cond = zero_in[1];
      OP_BGTZ: br_cond = zero_in[2];
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_src_o        = Branch_in & br_cond & ~mem_stall;
  assign branch_target_o = add_result_in;

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed self-checking bench for mem_stage_wb: loads, stores, wait states,
// branch resolution, reset during WAIT and (with MEM_TIMEOUT_EN) the timeout.
module tb_mem_stage_wb;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] add_result_in, result_in, Read_2_in;
  logic [2:0]  zero_in;
  logic [4:0]  RtorRd_in;
  logic [5:0]  OpCode_in;
  logic        MemWr_in, MemRead_in, Branch_in, RegWr_in;
  logic [1:0]  MemtoReg_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall, pc_src_o;
  logic [31:0] branch_target_o, mem_data_o, result_o;
  logic [4:0]  RtorRd_o;
  logic [1:0]  MemtoReg_o;
  logic        RegWr_o, mem_err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_wb #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .add_result_in   (add_result_in),
    .result_in       (result_in),
    .Read_2_in       (Read_2_in),
    .zero_in         (zero_in),
    .RtorRd_in       (RtorRd_in),
    .OpCode_in       (OpCode_in),
    .MemWr_in        (MemWr_in),
    .MemRead_in      (MemRead_in),
    .Branch_in       (Branch_in),
    .RegWr_in        (RegWr_in),
    .MemtoReg_in     (MemtoReg_in),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_be         (dmem_be),
    .dmem_ready      (dmem_ready),
    .dmem_rdata      (dmem_rdata),
    .mem_stall       (mem_stall),
    .pc_src_o        (pc_src_o),
    .branch_target_o (branch_target_o),
    .mem_data_o      (mem_data_o),
    .result_o        (result_o),
    .RtorRd_o        (RtorRd_o),
    .MemtoReg_o      (MemtoReg_o),
    .RegWr_o         (RegWr_o),
    .mem_err_o       (mem_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic rd, input logic wr, input logic br,
                       input logic [31:0] res, input logic [31:0] st, input logic rw,
                       input logic [1:0] mtr, input logic [4:0] dst);
    OpCode_in   = op;
    MemRead_in  = rd;
    MemWr_in    = wr;
    Branch_in   = br;
    result_in   = res;
    Read_2_in   = st;
    RegWr_in    = rw;
    MemtoReg_in = mtr;
    RtorRd_in   = dst;
    #1;
  endtask

  task automatic respond(input logic rdy, input logic [31:0] data);
    dmem_ready = rdy;
    dmem_rdata = data;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    add_result_in = '0;
    zero_in = '0;
    respond(1'b0, 32'h0);
    drive(6'h00, 0, 0, 0, 32'h0, 32'h0, 0, MTR_ALU, 5'd0);
    #2;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_result", result_o, 32'h0);
    check("rst_memdata", mem_data_o, 32'h0);
    check("rst_regwr", 32'(RegWr_o), 32'd0);
    check("rst_err", 32'(mem_err_o), 32'd0);
    @(negedge clk) reset = 1'b0;
    tick();

    // lw, zero wait
    respond(1'b1, 32'h12345678);
    drive(OP_LW, 1, 0, 0, 32'h100, 32'h0, 1, MTR_MEM, 5'd5);
    check("lw_stall", 32'(mem_stall), 32'd0);
    check("lw_req", 32'(dmem_req), 32'd1);
    check("lw_addr", dmem_addr, 32'h100);
    check("lw_be", 32'(dmem_be), 32'hF);
    check("lw_we", 32'(dmem_we), 32'd0);
    tick();
    check("lw_data", mem_data_o, 32'h12345678);
    check("lw_regwr", 32'(RegWr_o), 32'd1);
    check("lw_rd", 32'(RtorRd_o), 32'd5);
    check("lw_result", result_o, 32'h100);
    check("lw_mtr", 32'(MemtoReg_o), 32'(MTR_MEM));

    // lb at 0x103, three wait cycles
    respond(1'b0, 32'h0);
    drive(OP_LB, 1, 0, 0, 32'h103, 32'h0, 1, MTR_MEM, 5'd6);
    check("lb_be", 32'(dmem_be), 32'h8);
    check("lb_addr", dmem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      check("lb_stall", 32'(mem_stall), 32'd1);
      check("lb_req", 32'(dmem_req), 32'd1);
      tick();
      check("lb_bubble_regwr", 32'(RegWr_o), 32'd0);
      check("lb_bubble_mtr", 32'(MemtoReg_o), 32'd0);
    end
    respond(1'b1, 32'h80FF_FFFF);
    check("lb_ready_stall", 32'(mem_stall), 32'd0);
    tick();
    check("lb_data", mem_data_o, 32'hFFFF_FF80);
    check("lb_regwr", 32'(RegWr_o), 32'd1);
    check("lb_rd", 32'(RtorRd_o), 32'd6);

    // lbu same address, back to back, one wait cycle
    respond(1'b0, 32'h0);
    drive(OP_LBU, 1, 0, 0, 32'h103, 32'h0, 1, MTR_MEM, 5'd7);
    check("lbu_stall", 32'(mem_stall), 32'd1);
    tick();
    check("lbu_bubble", 32'(RegWr_o), 32'd0);
    respond(1'b1, 32'h80FF_FFFF);
    tick();
    check("lbu_data", mem_data_o, 32'h0000_0080);
    check("lbu_rd", 32'(RtorRd_o), 32'd7);

    // misaligned lh uses lane addr[1]=0; lhu upper lane
    drive(OP_LH, 1, 0, 0, 32'h101, 32'h0, 1, MTR_MEM, 5'd8);
    respond(1'b1, 32'h1234_8765);
    check("lh_be", 32'(dmem_be), 32'h3);
    tick();
    check("lh_data", mem_data_o, 32'hFFFF_8765);
    drive(OP_LHU, 1, 0, 0, 32'h102, 32'h0, 1, MTR_MEM, 5'd8);
    respond(1'b1, 32'h9ABC_0000);
    tick();
    check("lhu_data", mem_data_o, 32'h0000_9ABC);

    // sh at 0x202 with one wait cycle
    respond(1'b0, 32'h0);
    drive(OP_SH, 0, 1, 0, 32'h202, 32'hAAAA_BEEF, 0, MTR_ALU, 5'd0);
    check("sh_be", 32'(dmem_be), 32'hC);
    check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    check("sh_we", 32'(dmem_we), 32'd1);
    check("sh_addr", dmem_addr, 32'h200);
    check("sh_stall", 32'(mem_stall), 32'd1);
    tick();
    check("sh_hold_we", 32'(dmem_we), 32'd1);
    check("sh_hold_be", 32'(dmem_be), 32'hC);
    respond(1'b1, 32'hDEAD_BEEF);
    check("sh_done_stall", 32'(mem_stall), 32'd0);
    tick();
    check("sh_regwr", 32'(RegWr_o), 32'd0);
    check("sh_memdata", mem_data_o, 32'h0);
    check("sh_result", result_o, 32'h202);

    // sb / sw lanes
    drive(OP_SB, 0, 1, 0, 32'h1, 32'h1234_5678, 0, MTR_ALU, 5'd0);
    check("sb_be", 32'(dmem_be), 32'h2);
    check("sb_wdata", dmem_wdata, 32'h7878_7878);
    drive(OP_SW, 0, 1, 0, 32'h8, 32'hCAFE_F00D, 0, MTR_ALU, 5'd0);
    check("sw_be", 32'(dmem_be), 32'hF);
    check("sw_wdata", dmem_wdata, 32'hCAFE_F00D);

    // both flags: store wins, no load data captured
    respond(1'b1, 32'h5555_5555);
    drive(OP_LW, 1, 1, 0, 32'h10, 32'h0, 1, MTR_MEM, 5'd3);
    check("both_we", 32'(dmem_we), 32'd1);
    tick();
    check("both_memdata", mem_data_o, 32'h0);

    // branches
    add_result_in = 32'h0000_0400;
    zero_in = 3'b001;
    drive(OP_BEQ, 0, 0, 1, 32'h0, 32'h0, 0, MTR_ALU, 5'd0);
    check("beq_taken", 32'(pc_src_o), 32'd1);
    check("beq_target", branch_target_o, 32'h400);
    zero_in = 3'b010;
    drive(OP_BGTZ, 0, 0, 1, 32'h0, 32'h0, 0, MTR_ALU, 5'd0);
    check("bgtz_not", 32'(pc_src_o), 32'd0);
    drive(OP_BLEZ, 0, 0, 1, 32'h0, 32'h0, 0, MTR_ALU, 5'd0);
    check("blez_taken", 32'(pc_src_o), 32'd1);
    zero_in = 3'b000;
    drive(OP_BNE, 0, 0, 1, 32'h0, 32'h0, 0, MTR_ALU, 5'd0);
    check("bne_taken", 32'(pc_src_o), 32'd1);
    zero_in = 3'b001;
    drive(OP_BEQ, 0, 0, 0, 32'h0, 32'h0, 0, MTR_ALU, 5'd0);
    check("beq_nobranch", 32'(pc_src_o), 32'd0);
    respond(1'b0, 32'h0);
    drive(OP_BEQ, 1, 0, 1, 32'h0, 32'h0, 0, MTR_ALU, 5'd0);
    check("br_stalled", 32'(pc_src_o), 32'd0);
    respond(1'b1, 32'h0);
    check("br_unstalled", 32'(pc_src_o), 32'd1);
    tick();

    // reset while in WAIT
    drive(6'h00, 0, 0, 0, 32'hABCD_0000, 32'h0, 1, MTR_ALU, 5'd9);
    tick();
    check("alu_result", result_o, 32'hABCD_0000);
    check("alu_rd", 32'(RtorRd_o), 32'd9);
    respond(1'b0, 32'h0);
    drive(OP_LW, 1, 0, 0, 32'h40, 32'h0, 1, MTR_MEM, 5'd4);
    tick();
    check("wait_stall", 32'(mem_stall), 32'd1);
    check("wait_hold_result", result_o, 32'hABCD_0000);
    check("wait_state", 32'(dut.state_q), 32'(ST_WAIT));
    reset = 1'b1;
    #1;
    check("rstw_req", 32'(dmem_req), 32'd0);
    check("rstw_stall", 32'(mem_stall), 32'd0);
    check("rstw_result", result_o, 32'h0);
    check("rstw_rd", 32'(RtorRd_o), 32'd0);
    check("rstw_state", 32'(dut.state_q), 32'(ST_IDLE));
    respond(1'b1, 32'h1111_2222);
    @(negedge clk) reset = 1'b0;
    #1;
    check("post_rst_stall", 32'(mem_stall), 32'd0);
    tick();
    check("post_rst_data", mem_data_o, 32'h1111_2222);
    check("post_rst_regwr", 32'(RegWr_o), 32'd1);

`ifdef MEM_TIMEOUT_EN
    respond(1'b0, 32'h0);
    drive(OP_LW, 1, 0, 0, 32'h300, 32'h0, 1, MTR_MEM, 5'd2);
    for (int i = 0; i < 4; i++) begin
      check("to_stall", 32'(mem_stall), 32'd1);
      check("to_err_low", 32'(mem_err_o), 32'd0);
      tick();
    end
    check("to_release", 32'(mem_stall), 32'd0);
    tick();
    check("to_err", 32'(mem_err_o), 32'd1);
    check("to_data", mem_data_o, 32'h0);
    check("to_regwr", 32'(RegWr_o), 32'd1);
    drive(6'h00, 0, 0, 0, 32'h5, 32'h0, 1, MTR_ALU, 5'd1);
    tick();
    check("to_err_sticky", 32'(mem_err_o), 32'd1);
`else
    check("err_tied_low", 32'(mem_err_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
